// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: format selects and skid-buffer states.
package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_ZIMM  = 3'b101;
    localparam logic [2:0] IMM_SHAMT = 3'b110;
    localparam logic [2:0] IMM_ILL   = 3'b111;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ONE    = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for every supported instruction format.
module imm_decode #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [31:0]     Instr,
    input  logic [2:0]      Immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    import imm_pkg::*;

    logic [11:0] i_field;
    logic [11:0] s_field;
    logic [12:0] b_field;
    logic [31:0] u_field;
    logic [20:0] j_field;
    logic        unused_opcode;

    assign i_field = Instr[31:20];
    assign s_field = {Instr[31:25], Instr[11:7]};
    assign b_field = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
    assign u_field = {Instr[31:12], 12'b0};
    assign j_field = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};

    // The opcode field never contributes to any immediate.
    assign unused_opcode = ^Instr[6:0];

    // Select and extend the field chosen by Immsrc; the reserved code yields zero and flags it.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (Immsrc)
            IMM_I:     imm = XLEN'($signed(i_field));
            IMM_S:     imm = XLEN'($signed(s_field));
            IMM_B:     imm = XLEN'($signed(b_field));
            IMM_U:     imm = XLEN'($signed(u_field));
            IMM_J:     imm = XLEN'($signed(j_field));
            IMM_ZIMM:  imm = XLEN'(Instr[19:15]);
            IMM_SHAMT: imm = XLEN'(Instr[20 +: SHAMT_W]);
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a 2-entry skid buffer: decode first, then register final values.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | nothing held, out_valid low
// ST_ONE   | main stage holds the beat being presented
// ST_FULL  | main presenting, skid holds the next beat; in_ready low
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instr,
    input  logic [2:0]      Immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic            Illegal
);
    import imm_pkg::*;

    logic [1:0]      state;
    logic [XLEN-1:0] main_imm;
    logic            main_ill;
    logic [XLEN-1:0] skid_imm;
    logic            skid_ill;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic            accept;
    logic            deliver;

    imm_decode #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .Instr   (Instr),
        .Immsrc  (Immsrc),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    // in_ready comes straight from registered state so out_ready never reaches it combinationally.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign ImmExt    = main_imm;
    assign Illegal   = main_ill;

    // Skid-buffer sequencing: main stage always presents the oldest beat, skid catches one during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            main_imm <= '0;
            main_ill <= 1'b0;
            skid_imm <= '0;
            skid_ill <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_imm <= dec_imm;
                        main_ill <= dec_ill;
                        state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_imm <= dec_imm;
                        main_ill <= dec_ill;
                    end else if (accept) begin
                        skid_imm <= dec_imm;
                        skid_ill <= dec_ill;
                        state    <= ST_FULL;
                    end else if (deliver) begin
                        state    <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        main_imm <= skid_imm;
                        main_ill <= skid_ill;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances driven in lockstep against a queue model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  immsrc;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) u32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .Instr     (instr),
        .Immsrc    (immsrc),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .ImmExt    (imm32),
        .Illegal   (ill32)
    );

    imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) u64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .Instr     (instr),
        .Immsrc    (immsrc),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .ImmExt    (imm64),
        .Illegal   (ill64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
    } beat_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        ill;
    } vec_t;

    beat_t q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    delivered = 0;

    // Reference immediate from the format rules, as plain signed arithmetic on bit fields.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit x64);
        longint v;
        v = 0;
        case (src)
            3'd0: begin
                v = longint'(ins[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            3'd1: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
            end
            3'd3: begin
                v = longint'(ins[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
            end
            3'd4: begin
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare both instances against the model queue (head = beat being presented).
    task automatic check_outputs();
        logic        exp_rdy;
        logic        exp_ov;
        logic [63:0] r32;
        logic [63:0] r64;
        exp_rdy = (q.size() < 2);
        exp_ov  = (q.size() > 0);
        chk("in_ready32",  64'(in_ready32),  64'(exp_rdy));
        chk("in_ready64",  64'(in_ready64),  64'(exp_rdy));
        chk("out_valid32", 64'(out_valid32), 64'(exp_ov));
        chk("out_valid64", 64'(out_valid64), 64'(exp_ov));
        if (exp_ov) begin
            r32 = ref_imm(q[0].instr, q[0].src, 1'b0);
            r64 = ref_imm(q[0].instr, q[0].src, 1'b1);
            chk("imm32", 64'(imm32), {32'b0, r32[31:0]});
            chk("imm64", imm64, r64);
            chk("ill32", 64'(ill32), 64'(q[0].src == 3'b111));
            chk("ill64", 64'(ill64), 64'(q[0].src == 3'b111));
        end
    endtask

    // One cycle: drive inputs, check, clock, advance the model by the handshakes that fired.
    task automatic tick(input logic v, input logic [31:0] ins, input logic [2:0] s, input logic ordy);
        logic acc;
        logic del;
        beat_t b;
        in_valid  = v;
        instr     = ins;
        immsrc    = s;
        out_ready = ordy;
        check_outputs();
        @(posedge clk);
        acc = v && (q.size() < 2);
        del = ordy && (q.size() > 0);
        if (del) begin
            void'(q.pop_front());
            delivered++;
        end
        if (acc) begin
            b.instr = ins;
            b.src   = s;
            q.push_back(b);
        end
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h800000EF, 3'd4, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[2]  = '{32'h800000EF, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[3]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[4]  = '{32'h7E000FA3, 3'd1, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[5]  = '{32'h80000023, 3'd1, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0};
        vecs[6]  = '{32'h800F8000, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[7]  = '{32'h03F00000, 3'd6, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[8]  = '{32'h02000000, 3'd6, 32'h00000000, 64'h0000000000000020, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[10] = '{32'h7FF00013, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[11] = '{32'h7FFFF06F, 3'd4, 32'h000FFFFE, 64'h00000000000FFFFE, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'h0;
        immsrc    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready",  64'(in_ready64),  64'd1);
        chk("rst_imm32",     64'(imm32),       64'd0);
        chk("rst_imm64",     imm64,            64'd0);
        chk("rst_ill",       64'(ill32 | ill64), 64'd0);
        rst_n = 1'b1;

        // Single beats through an always-ready sink; each result visible one cycle later.
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, vecs[i].instr, vecs[i].src, 1'b1);
            chk("vec_imm32", 64'(imm32), {32'b0, vecs[i].exp32});
            chk("vec_imm64", imm64, vecs[i].exp64);
            chk("vec_ill",   64'(ill64), 64'(vecs[i].ill));
        end
        tick(1'b0, 32'h0, 3'd0, 1'b1);
        tick(1'b0, 32'h0, 3'd0, 1'b1);

        // Stalled sink: two beats fill the buffer, the third waits until the first leaves.
        tick(1'b1, 32'h00100093, 3'd0, 1'b0);
        tick(1'b1, 32'h00200093, 3'd0, 1'b0);
        chk("full_in_ready", 64'(in_ready32), 64'd0);
        chk("full_head",     64'(imm32),      64'd1);
        tick(1'b1, 32'h00300093, 3'd0, 1'b0);
        chk("stall_hold",    64'(imm32),      64'd1);
        tick(1'b1, 32'h00300093, 3'd0, 1'b1);
        chk("second_out",    64'(imm32),      64'd2);
        tick(1'b1, 32'h00300093, 3'd0, 1'b1);
        chk("third_out",     64'(imm32),      64'd3);
        tick(1'b0, 32'h0, 3'd0, 1'b1);

        // Asynchronous reset while full, between clock edges.
        tick(1'b1, 32'h00100093, 3'd0, 1'b0);
        tick(1'b1, 32'h00200093, 3'd0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid32), 64'd0);
        chk("arst_in_ready",  64'(in_ready32),  64'd1);
        chk("arst_imm64",     imm64,            64'd0);
        chk("arst_ill",       64'(ill32),       64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 32'hFE000EE3, 3'd2, 1'b1);
        chk("post_rst_b32",   64'(imm32),       64'hFFFFFFFC);
        chk("post_rst_valid", 64'(out_valid32), 64'd1);
        tick(1'b0, 32'h0, 3'd0, 1'b1);

        // Random handshakes; the model checks order, values and stall stability every cycle.
        delivered = 0;
        for (int cyc = 0; cyc < 40000 && delivered < 10000; cyc++) begin
            tick($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0);
        end
        chk("random_beats", 64'(delivered), 64'd10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32, 64.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount field width; SHALL equal 5 when XLEN=32 and 6 when XLEN=64.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction beat valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-007 SHALL have port Instr  input  32  instruction word.
REQ-008 SHALL have port Immsrc  input  3  immediate format select.
REQ-009 SHALL have port out_valid  output  1  ImmExt/Illegal hold a valid beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port ImmExt  output  XLEN  generated immediate.
REQ-012 SHALL have port Illegal  output  1  beat carried an undefined Immsrc.

Function
REQ-013 Immsrc 000 (I) SHALL give sign-extend(Instr[31:20]).
REQ-014 Immsrc 001 (S) SHALL give sign-extend({Instr[31:25],Instr[11:7]}).
REQ-015 Immsrc 010 (B) SHALL give sign-extend({Instr[31],Instr[7],Instr[30:25],Instr[11:8],1'b0}).
REQ-016 Immsrc 011 (U) SHALL give sign-extend({Instr[31:12],12'b0}) to XLEN.
REQ-017 Immsrc 100 (J) SHALL give sign-extend({Instr[31],Instr[19:12],Instr[20],Instr[30:21],1'b0}).
REQ-018 Immsrc 101 (ZIMM) SHALL give zero-extend(Instr[19:15]).
REQ-019 Immsrc 110 (SHAMT) SHALL give zero-extend(Instr[20+SHAMT_W-1:20]).
REQ-020 Immsrc 111 SHALL give ImmExt=0 and Illegal=1; all other codes give Illegal=0.
REQ-021 Beat accepted when in_valid && in_ready; beat delivered when out_valid && out_ready.
REQ-022 Latency SHALL be exactly 1 cycle: beat accepted in cycle N appears on outputs in cycle N+1 if output stage empty or draining.
REQ-023 Datapath SHALL be a 2-entry skid buffer (main stage + skid stage); throughput 1 beat/cycle with out_ready held high.
REQ-024 in_ready SHALL equal !skid_valid (registered, no combinational path from out_ready).
REQ-025 States: EMPTY (no entry), ONE (main only), FULL (main+skid); out_valid=1 in ONE and FULL.
REQ-026 EMPTY + accept -> ONE; ONE + accept + deliver -> ONE (main reloads); ONE + accept, no deliver -> FULL (new beat to skid); ONE + deliver only -> EMPTY.
REQ-027 FULL + deliver -> ONE with skid moved to main; FULL accepts nothing (in_ready=0).
REQ-028 Beats SHALL be delivered in acceptance order; none dropped or duplicated.
REQ-029 While out_valid && !out_ready, ImmExt and Illegal SHALL hold stable.
REQ-030 Decode SHALL occur before registering; stored values are final immediates.
REQ-031 Instr/Immsrc ignored when in_valid=0 or in_ready=0.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) force state EMPTY: out_valid=0, in_ready=1, ImmExt=0, Illegal=0.
REQ-033 Reset mid-operation SHALL discard both stored beats; first accept after deassertion behaves as from EMPTY.
REQ-034 Reset deassertion SHALL be used synchronously to clk (no accept in the deasserting cycle's edge being lost beyond normal handshake).

Structure
REQ-035 Package imm_pkg SHALL hold the Immsrc encodings (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_ZIMM, IMM_SHAMT, IMM_ILL) and the skid-state encoding.
REQ-036 Combinational format decode SHALL be a sub-module imm_decode (Instr, Immsrc -> imm, illegal), parametrised by XLEN/SHAMT_W.
REQ-037 imm_gen_pipe SHALL contain only the skid buffer, handshake logic and one imm_decode instance.

Verification
REQ-038 XLEN=32, Instr=0xFFF00093, Immsrc=000, out_ready=1 -> next cycle ImmExt=0xFFFFFFFF, Illegal=0.
REQ-039 XLEN=64, Instr=0x800000EF, Immsrc=100 -> ImmExt=0xFFFFFFFFFFF00000; Immsrc=011 same Instr -> 0xFFFFFFFF80000000.
REQ-040 out_ready=0, 3 consecutive in_valid beats -> 2 accepted, in_ready=0 from cycle 2; release out_ready -> beats emerge in order, third accepted after first delivery.
REQ-041 Immsrc=111, any Instr -> ImmExt=0, Illegal=1; Immsrc=110, XLEN=64, Instr[25:20]=6'h3F -> ImmExt=63.
REQ-042 State FULL, assert rst_n=0 between edges -> out_valid=0, in_ready=1 immediately; post-reset beat B-type Instr=0xFE000EE3 -> ImmExt=0xFFFFFFFC (XLEN=32).
REQ-043 Random in_valid/out_ready, 10k beats vs scoreboard model -> zero mismatches, order preserved, stable-hold under stall.
